axis_dispatcher: RTL and testbench
==================================

AXIS_DISPATCHER -- requirements
Module: axis_dispatcher

Interface
REQ-001 Parameter DATAW, default 512; width of the payload vector.
REQ-002 Parameter USERW, default 75; width of the header appended above the payload on the link.
REQ-003 Parameter IDW, default 2; tid width.
REQ-004 Parameter DESTW, default 4; tdest width.
REQ-005 Parameter DESTNODE, default 0; mesh node ID placed on every beat's tdest.
REQ-006 Parameter FIFO_DEPTH, default 8; buffer entries, power of two, at least 2.
REQ-007 Parameter USER_CMD, default 2'h2; command code placed in header bits [10:9].
REQ-008 The block SHALL use one clock, clk, and an asynchronous active-low reset, rst_n.
REQ-009 Port: clk  in  1  clock; all state on rising edge.
REQ-010 Port: rst_n  in  1  asynchronous active-low reset.
REQ-011 Port: data_fifo_wen  in  1  write strobe for one payload vector.
REQ-012 Port: data_fifo_wdata  in  DATAW  payload vector.
REQ-013 Port: data_last  in  1  marks the written vector as the packet's final beat.
REQ-014 Port: data_fifo_rdy  out  1  buffer can accept a write this cycle.
REQ-015 Port: axis_tx_tvalid  out  1  AXI-Stream valid.
REQ-016 Port: axis_tx_tready  in  1  AXI-Stream ready.
REQ-017 Port: axis_tx_tdata  out  DATAW+USERW  {header, payload}; payload in [DATAW-1:0].
REQ-018 Port: axis_tx_tlast  out  1  final beat of the packet.
REQ-019 Port: axis_tx_tid  out  IDW  constant 0.
REQ-020 Port: axis_tx_tdest  out  DESTW  constant DESTNODE.

Function
REQ-021 The block SHALL hold up to FIFO_DEPTH entries of {data_last, data_fifo_wdata} in a first-in-first-out buffer.
REQ-022 data_fifo_rdy SHALL be 1 exactly when the stored count is below FIFO_DEPTH, derived only from registered state.
REQ-023 A write SHALL occur when data_fifo_wen=1 and data_fifo_rdy=1. A wen while rdy=0 SHALL be dropped, with no state change.
REQ-024 axis_tx_tvalid SHALL be 1 exactly when the count is nonzero, and SHALL present the head entry show-ahead.
REQ-025 A pop SHALL occur when axis_tx_tvalid=1 and axis_tx_tready=1.
REQ-026 A push and a pop in the same cycle SHALL leave the count unchanged. The push is allowed only if rdy was 1 at the start of that cycle.
REQ-027 Latency: a write into an empty buffer SHALL raise tvalid on the next rising edge.
REQ-028 While tvalid=1 and tready=0, tdata, tlast, tid and tdest SHALL hold stable.
REQ-029 Header layout: bits [8:0] zero, bits [10:9] USER_CMD, bits [USERW-1:11] zero.
REQ-030 axis_tx_tlast SHALL equal the stored data_last of the head entry.
REQ-031 Read and write pointers SHALL wrap modulo FIFO_DEPTH without losing or duplicating entries.

Reset
REQ-032 While rst_n=0, the buffer SHALL be empty, with axis_tx_tvalid=0, axis_tx_tlast=0 and data_fifo_rdy=1.
REQ-033 Assertion of rst_n mid-transfer SHALL discard all stored entries immediately, without waiting for a clock edge.
REQ-034 Writes SHALL be accepted from the first rising edge after rst_n deasserts.

Configuration
REQ-035 With macro DISPATCHER_STATS_EN defined, the block SHALL add outputs beat_count[31:0] and packet_count[31:0].
REQ-036 beat_count SHALL count pops and packet_count SHALL count pops with tlast=1. Both reset to 0 and wrap at 2^32.
REQ-037 Without DISPATCHER_STATS_EN, these ports and counters SHALL be absent.

Verification
REQ-038 Reset, then write 0xAB in lane 0 with last=1, with tready=1 -> next cycle tvalid=1, tdata[7:0]=0xAB, tdata[DATAW+10:DATAW+9]=2'h2, tlast=1, tdest=DESTNODE; tvalid=0 the cycle after.
REQ-039 With tready=0, write 8 vectors -> rdy=0 after the 8th write; a 9th wen is dropped; raising tready yields exactly the 8 vectors in order.
REQ-040 Hold tready=0 for 3 cycles with a valid head -> tdata and tlast remain unchanged.
REQ-041 With the buffer full, tready=1 and wen=1 in the same cycle -> the write is dropped; rdy=1 next cycle; the count is 7.
REQ-042 Stream 20 vectors (last on the 20th) with tready toggling every cycle -> all 20 arrive in order; only the 20th has tlast; with DISPATCHER_STATS_EN, beat_count=20 and packet_count=1.
REQ-043 Assert rst_n=0 with 5 entries stored -> tvalid falls without a clock edge; rdy=1; no old data appears after release.

Source files
------------

// File: rtl/axis_dispatcher.sv
// AXI-Stream dispatcher: buffers payload vectors in a show-ahead FIFO and
// emits them as {header, payload} beats. Define DISPATCHER_STATS_EN for beat/packet counters.
module axis_dispatcher #(
  parameter int           DATAW      = 512,
  parameter int           USERW      = 75,
  parameter int           IDW        = 2,
  parameter int           DESTW      = 4,
  parameter int           DESTNODE   = 0,
  parameter int           FIFO_DEPTH = 8,
  parameter logic [1:0]   USER_CMD   = 2'h2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   data_fifo_wen,
  input  logic [DATAW-1:0]       data_fifo_wdata,
  input  logic                   data_last,
  output logic                   data_fifo_rdy,
  output logic                   axis_tx_tvalid,
  input  logic                   axis_tx_tready,
  output logic [DATAW+USERW-1:0] axis_tx_tdata,
  output logic                   axis_tx_tlast,
  output logic [IDW-1:0]         axis_tx_tid,
  output logic [DESTW-1:0]       axis_tx_tdest
`ifdef DISPATCHER_STATS_EN
  ,
  output logic [31:0]            beat_count,
  output logic [31:0]            packet_count
`endif
);

  localparam int PTRW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNTW = PTRW + 1;
  localparam int ENTW = DATAW + 1;

  // Header is constant: command code in [10:9], everything else zero.
  localparam logic [USERW-1:0] HEADER = USERW'(USER_CMD) << 9;

  logic [ENTW-1:0] mem [FIFO_DEPTH];
  logic [PTRW-1:0] wr_ptr;
  logic [PTRW-1:0] rd_ptr;
  logic [CNTW-1:0] count;
  logic            push;
  logic            pop;
  logic [ENTW-1:0] head;

  assign data_fifo_rdy  = (count != CNTW'(FIFO_DEPTH));
  assign axis_tx_tvalid = (count != '0);
  assign push           = data_fifo_wen & data_fifo_rdy;
  assign pop            = axis_tx_tvalid & axis_tx_tready;

  // Storage needs no reset; an empty count makes stale entries invisible.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {data_last, data_fifo_wdata};
    end
  end

  // Pointers wrap naturally because FIFO_DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTRW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTRW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CNTW'(1);
        2'b01:   count <= count - CNTW'(1);
        default: count <= count;
      endcase
    end
  end

  assign head          = mem[rd_ptr];
  assign axis_tx_tdata = {HEADER, head[DATAW-1:0]};
  assign axis_tx_tlast = axis_tx_tvalid & head[DATAW];
  assign axis_tx_tid   = '0;
  assign axis_tx_tdest = DESTW'(DESTNODE);

`ifdef DISPATCHER_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_count   <= '0;
      packet_count <= '0;
    end else if (pop) begin
      beat_count <= beat_count + 32'd1;
      if (axis_tx_tlast) begin
        packet_count <= packet_count + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_axis_dispatcher.sv
// Directed self-checking bench for axis_dispatcher.
module tb_axis_dispatcher;

  localparam int DATAW      = 512;
  localparam int USERW      = 75;
  localparam int IDW        = 2;
  localparam int DESTW      = 4;
  localparam int DESTNODE   = 3;
  localparam int FIFO_DEPTH = 8;
  localparam int TW         = DATAW + USERW;

  // Header with command 2'h2 in bits [10:9].
  localparam logic [USERW-1:0] HDR = {{(USERW-11){1'b0}}, 2'h2, 9'b0};

  logic             clk = 1'b0;
  logic             rst_n;
  logic             data_fifo_wen;
  logic [DATAW-1:0] data_fifo_wdata;
  logic             data_last;
  logic             data_fifo_rdy;
  logic             axis_tx_tvalid;
  logic             axis_tx_tready;
  logic [TW-1:0]    axis_tx_tdata;
  logic             axis_tx_tlast;
  logic [IDW-1:0]   axis_tx_tid;
  logic [DESTW-1:0] axis_tx_tdest;
`ifdef DISPATCHER_STATS_EN
  logic [31:0]      beat_count;
  logic [31:0]      packet_count;
`endif

  int vectors    = 0;
  int miscompares = 0;

  axis_dispatcher #(
    .DATAW(DATAW), .USERW(USERW), .IDW(IDW), .DESTW(DESTW),
    .DESTNODE(DESTNODE), .FIFO_DEPTH(FIFO_DEPTH), .USER_CMD(2'h2)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .data_fifo_wen(data_fifo_wen),
    .data_fifo_wdata(data_fifo_wdata),
    .data_last(data_last),
    .data_fifo_rdy(data_fifo_rdy),
    .axis_tx_tvalid(axis_tx_tvalid),
    .axis_tx_tready(axis_tx_tready),
    .axis_tx_tdata(axis_tx_tdata),
    .axis_tx_tlast(axis_tx_tlast),
    .axis_tx_tid(axis_tx_tid),
    .axis_tx_tdest(axis_tx_tdest)
`ifdef DISPATCHER_STATS_EN
    ,
    .beat_count(beat_count),
    .packet_count(packet_count)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [TW-1:0] expBeat(input int unsigned payload);
    return {HDR, DATAW'(payload)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic wen, input int unsigned wdata,
                               input logic last, input logic ready);
    data_fifo_wen   = wen;
    data_fifo_wdata = DATAW'(wdata);
    data_last       = last;
    axis_tx_tready  = ready;
  endtask

  task automatic checkOutput(input string tag, input logic [TW-1:0] obs,
                             input logic [TW-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    int wr_idx;
    int rd_idx;
    int cyc;
    logic push_now;
    logic pop_now;
    logic [TW-1:0] held_data;
    logic held_last;

    rst_n = 1'b0;
    applyStimulus(1'b0, 0, 1'b0, 1'b0);
    #12;
    checkOutput("reset_tvalid", TW'(axis_tx_tvalid), TW'(0));
    checkOutput("reset_tlast", TW'(axis_tx_tlast), TW'(0));
    checkOutput("reset_rdy", TW'(data_fifo_rdy), TW'(1));
    checkOutput("reset_tid", TW'(axis_tx_tid), TW'(0));
    checkOutput("reset_tdest", TW'(axis_tx_tdest), TW'(DESTNODE));

    // Single beat written on the first edge after reset release.
    rst_n = 1'b1;
    applyStimulus(1'b1, 'hAB, 1'b1, 1'b1);
    tick();
    applyStimulus(1'b0, 0, 1'b0, 1'b1);
    checkOutput("single_tvalid", TW'(axis_tx_tvalid), TW'(1));
    checkOutput("single_tdata", axis_tx_tdata, expBeat('hAB));
    checkOutput("single_cmd", TW'(axis_tx_tdata[DATAW+10 -: 2]), TW'(2'h2));
    checkOutput("single_tlast", TW'(axis_tx_tlast), TW'(1));
    checkOutput("single_tdest", TW'(axis_tx_tdest), TW'(DESTNODE));
    tick();
    checkOutput("single_drained", TW'(axis_tx_tvalid), TW'(0));

    // Fill with 8 vectors while the sink stalls.
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b1, i + 1, (i == 7), 1'b0);
      tick();
    end
    checkOutput("full_rdy", TW'(data_fifo_rdy), TW'(0));
    applyStimulus(1'b1, 'hDEAD, 1'b1, 1'b0);
    tick();
    applyStimulus(1'b0, 0, 1'b0, 1'b0);
    checkOutput("full_drop_rdy", TW'(data_fifo_rdy), TW'(0));
    checkOutput("full_head", axis_tx_tdata, expBeat(1));

    // Head stays stable under backpressure.
    held_data = axis_tx_tdata;
    held_last = axis_tx_tlast;
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput("hold_tdata", axis_tx_tdata, held_data);
      checkOutput("hold_tlast", TW'(axis_tx_tlast), TW'(held_last));
    end

    // Full: simultaneous wen and pop, write is dropped.
    applyStimulus(1'b1, 'hBEEF, 1'b0, 1'b1);
    tick();
    applyStimulus(1'b0, 0, 1'b0, 1'b1);
    checkOutput("popfull_rdy", TW'(data_fifo_rdy), TW'(1));
    for (int i = 2; i <= 8; i++) begin
      checkOutput("drain_tvalid", TW'(axis_tx_tvalid), TW'(1));
      checkOutput("drain_tdata", axis_tx_tdata, expBeat(i));
      checkOutput("drain_tlast", TW'(axis_tx_tlast), TW'(i == 8));
      tick();
    end
    checkOutput("drain_empty", TW'(axis_tx_tvalid), TW'(0));

    // Stream 20 vectors with ready toggling; pointers wrap more than once.
    wr_idx = 0;
    rd_idx = 0;
    cyc    = 0;
    while (rd_idx < 20 && cyc < 200) begin
      applyStimulus(wr_idx < 20, 100 + wr_idx, (wr_idx == 19), (cyc % 2) == 1);
      push_now = data_fifo_wen && data_fifo_rdy;
      pop_now  = axis_tx_tvalid && axis_tx_tready;
      if (pop_now) begin
        checkOutput("stream_tdata", axis_tx_tdata, expBeat(100 + rd_idx));
        checkOutput("stream_tlast", TW'(axis_tx_tlast), TW'(rd_idx == 19));
        rd_idx++;
      end
      if (push_now) wr_idx++;
      tick();
      cyc++;
    end
    applyStimulus(1'b0, 0, 1'b0, 1'b0);
    checkOutput("stream_count", TW'(rd_idx), TW'(20));
    checkOutput("stream_empty", TW'(axis_tx_tvalid), TW'(0));
`ifdef DISPATCHER_STATS_EN
    checkOutput("stats_beats", TW'(beat_count), TW'(29));
    checkOutput("stats_packets", TW'(packet_count), TW'(3));
`endif

    // Asynchronous reset with 5 entries stored.
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, 'h500 + i, 1'b0, 1'b0);
      tick();
    end
    applyStimulus(1'b0, 0, 1'b0, 1'b0);
    checkOutput("prereset_tvalid", TW'(axis_tx_tvalid), TW'(1));
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async_tvalid", TW'(axis_tx_tvalid), TW'(0));
    checkOutput("async_rdy", TW'(data_fifo_rdy), TW'(1));
    checkOutput("async_tlast", TW'(axis_tx_tlast), TW'(0));
`ifdef DISPATCHER_STATS_EN
    checkOutput("async_beats", TW'(beat_count), TW'(0));
`endif
    #2;
    rst_n = 1'b1;
    applyStimulus(1'b0, 0, 1'b0, 1'b1);
    tick();
    tick();
    checkOutput("post_reset_empty", TW'(axis_tx_tvalid), TW'(0));
    applyStimulus(1'b1, 'h77, 1'b1, 1'b1);
    tick();
    applyStimulus(1'b0, 0, 1'b0, 1'b1);
    checkOutput("post_reset_tvalid", TW'(axis_tx_tvalid), TW'(1));
    checkOutput("post_reset_tdata", axis_tx_tdata, expBeat('h77));
    checkOutput("post_reset_tlast", TW'(axis_tx_tlast), TW'(1));
    tick();
    checkOutput("post_reset_drained", TW'(axis_tx_tvalid), TW'(0));
`ifdef DISPATCHER_STATS_EN
    checkOutput("post_reset_beats", TW'(beat_count), TW'(1));
    checkOutput("post_reset_packets", TW'(packet_count), TW'(1));
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
